// File: rtl/riscv_lsu.sv
// Load/store unit: turns core byte/half/word accesses into aligned word transactions
// with byte enables, stalls the core until completion and returns extended load data.
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} lsuState_e;

    lsuState_e   stateQ, stateD;
    logic        memReqQ, memReqD;
    logic        memWeQ, memWeD;
    logic [3:0]  memBeQ, memBeD;
    logic [31:0] memAddrQ, memAddrD;
    logic [31:0] memWdQ, memWdD;
    logic [2:0]  sizeQ, sizeD;
    logic [1:0]  offQ, offD;
    logic        errQ, errD;
    logic [31:0] rdQ, rdD;
    logic [31:0] cntQ, cntD;

    logic        sizeValid;
    logic        aligned;
    logic [3:0]  reqBe;
    logic [31:0] reqWd;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadExt;

    // Request decode straight from the core port (only used in IDLE)
    always_comb begin
        sizeValid = 1'b0;
        aligned   = 1'b0;
        reqBe     = 4'b0000;
        reqWd     = core_wd_i;
        unique case (core_size_i)
            3'd0, 3'd4: begin
                sizeValid = 1'b1;
                aligned   = 1'b1;
                reqBe     = 4'b0001 << core_addr_i[1:0];
                reqWd     = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                sizeValid = 1'b1;
                aligned   = ~core_addr_i[0];
                reqBe     = 4'b0011 << core_addr_i[1:0];
                reqWd     = {2{core_wd_i[15:0]}};
            end
            3'd2: begin
                sizeValid = 1'b1;
                aligned   = (core_addr_i[1:0] == 2'b00);
                reqBe     = 4'b1111;
            end
            default: ;
        endcase
    end

    // Lane selection and extension of the returned memory word
    always_comb begin
        loadByte = mem_rd_i[8*offQ +: 8];
        loadHalf = offQ[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        loadExt  = 32'd0;
        unique case (sizeQ)
            3'd0:    loadExt = {{24{loadByte[7]}}, loadByte};
            3'd1:    loadExt = {{16{loadHalf[15]}}, loadHalf};
            3'd2:    loadExt = mem_rd_i;
            3'd4:    loadExt = {24'd0, loadByte};
            3'd5:    loadExt = {16'd0, loadHalf};
            default: loadExt = 32'd0;
        endcase
    end

    always_comb begin
        stateD       = stateQ;
        memReqD      = memReqQ;
        memWeD       = memWeQ;
        memBeD       = memBeQ;
        memAddrD     = memAddrQ;
        memWdD       = memWdQ;
        sizeD        = sizeQ;
        offD         = offQ;
        errD         = errQ;
        rdD          = rdQ;
        cntD         = cntQ;
        core_stall_o = 1'b0;

        unique case (stateQ)
            StIdle: begin
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    if (sizeValid && aligned) begin
                        memReqD  = 1'b1;
                        memWeD   = core_we_i;
                        memBeD   = reqBe;
                        memAddrD = {core_addr_i[31:2], 2'b00};
                        memWdD   = reqWd;
                        sizeD    = core_size_i;
                        offD     = core_addr_i[1:0];
                        cntD     = 32'd0;
                        stateD   = StReq;
                    end else begin
                        errD   = 1'b1;
                        rdD    = 32'd0;
                        stateD = StDone;
                    end
                end
            end
            StReq: begin
                core_stall_o = 1'b1;
                if (mem_ready_i) begin
                    memReqD = 1'b0;
                    errD    = 1'b0;
                    rdD     = memWeQ ? 32'd0 : loadExt;
                    stateD  = StDone;
                end else begin
                    cntD = cntQ + 32'd1;
                    if ((TIMEOUT_CYCLES != 0) && (cntQ + 32'd1 == TIMEOUT_CYCLES)) begin
                        memReqD = 1'b0;
                        errD    = 1'b1;
                        rdD     = 32'd0;
                        stateD  = StDone;
                    end
                end
            end
            StDone: begin
                errD   = 1'b0;
                rdD    = 32'd0;
                cntD   = 32'd0;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stateQ   <= StIdle;
            memReqQ  <= 1'b0;
            memWeQ   <= 1'b0;
            memBeQ   <= 4'b0000;
            memAddrQ <= 32'd0;
            memWdQ   <= 32'd0;
            sizeQ    <= 3'd0;
            offQ     <= 2'd0;
            errQ     <= 1'b0;
            rdQ      <= 32'd0;
            cntQ     <= 32'd0;
        end else begin
            stateQ   <= stateD;
            memReqQ  <= memReqD;
            memWeQ   <= memWeD;
            memBeQ   <= memBeD;
            memAddrQ <= memAddrD;
            memWdQ   <= memWdD;
            sizeQ    <= sizeD;
            offQ     <= offD;
            errQ     <= errD;
            rdQ      <= rdD;
            cntQ     <= cntD;
        end
    end

    assign mem_req_o  = memReqQ;
    assign mem_we_o   = memWeQ;
    assign mem_be_o   = memBeQ;
    assign mem_addr_o = memAddrQ;
    assign mem_wd_o   = memWdQ;
    assign core_err_o = errQ;
    assign core_rd_o  = rdQ;

endmodule
